// File: rtl/spi_tx_fifo.sv
// Transmit FIFO between the command handler and the SPI slave write port.
// Queued words are drained one at a time as strobes separated by a gap cycle.
module spi_tx_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     spi_wr_buffer_free,
  output logic                     spi_wr_en,
  output logic [WIDTH-1:0]         spi_wr_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [AW:0]      count;
  state_t           state;
  logic             do_push, do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign level = count;

  // full and empty come from the pre-edge count, so a push into a full FIFO
  // is dropped even when the drain pops in the same cycle
  assign do_push = push & ~flush & ~full;
  assign do_pop  = (state == IDLE) & ~empty & spi_wr_buffer_free & ~flush;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      state       <= IDLE;
      overflow    <= 1'b0;
      spi_wr_en   <= 1'b0;
      spi_wr_data <= '0;
    end else if (flush) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      state     <= IDLE;
      overflow  <= 1'b0;
      spi_wr_en <= 1'b0;
    end else begin
      if (push && full) overflow <= 1'b1;
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          spi_wr_en <= 1'b0;
          if (do_pop) begin
            spi_wr_data <= mem[rptr];
            spi_wr_en   <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          spi_wr_en <= 1'b0;
          state     <= GAP;
        end
        default: begin
          spi_wr_en <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Randomized and directed bench for spi_tx_fifo against a queue-based model
// with a pop cool-down counter.
module tb_spi_tx_fifo;

  localparam int W = 24;
  localparam int D = 8;

  logic         CLK = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         push = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         spi_wr_buffer_free = 1'b0;
  logic         full, empty, overflow, spi_wr_en;
  logic [3:0]   level;
  logic [W-1:0] spi_wr_data;

  spi_tx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .resetn(resetn), .flush(flush), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .spi_wr_buffer_free(spi_wr_buffer_free), .spi_wr_en(spi_wr_en),
    .spi_wr_data(spi_wr_data)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] q[$];
  int           busy;
  bit           m_ov, m_en;
  logic [W-1:0] m_data;
  int           strobes;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("spi_wr_en", 32'(spi_wr_en), 32'(m_en));
    check_val("spi_wr_data", 32'(spi_wr_data), 32'(m_data));
    check_val("level", 32'(level), 32'(q.size()));
    check_val("full", 32'(full), 32'(q.size() == D));
    check_val("empty", 32'(empty), 32'(q.size() == 0));
    check_val("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic model_reset();
    q.delete();
    busy   = 0;
    m_ov   = 1'b0;
    m_en   = 1'b0;
    m_data = '0;
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after.
  task automatic cycle(input bit p, input logic [W-1:0] d, input bit f, input bit fl);
    bit was_full;
    push = p; push_data = d; spi_wr_buffer_free = f; flush = fl;
    @(posedge CLK);
    was_full = (q.size() == D);
    if (fl) begin
      q.delete();
      busy = 0;
      m_ov = 1'b0;
      m_en = 1'b0;
    end else begin
      if (busy == 0 && q.size() > 0 && f) begin
        m_data = q.pop_front();
        m_en   = 1'b1;
        busy   = 2;
      end else begin
        m_en = 1'b0;
        if (busy > 0) busy--;
      end
      if (p) begin
        if (was_full) m_ov = 1'b1;
        else q.push_back(d);
      end
    end
    #1;
    if (spi_wr_en) strobes++;
    check_all();
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, f, 1'b0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("rst_en_now", 32'(spi_wr_en), 32'd0);
    @(posedge CLK);
    #1;
    check_all();
    resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    strobes = 0;
    #2;
    check_all();
    resetn = 1'b1;

    // single word latency
    cycle(1'b1, 24'hABCDEF, 1'b1, 1'b0);
    check_val("lat_level1", 32'(level), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("lat_strobe", 32'(spi_wr_en), 32'd1);
    check_val("lat_data", 32'(spi_wr_data), 32'hABCDEF);
    idle(3, 1'b1);

    // fill while stalled, overflow, then drain in order
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    cycle(1'b1, 24'h000009, 1'b0, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    strobes = 0;
    idle(30, 1'b1);
    check_val("drain_strobes", 32'(strobes), 32'd8);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // repeated fill/drain across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
      idle(30, 1'b1);
    end

    // flush with a simultaneous push while full
    for (int i = 0; i < 8; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    cycle(1'b1, W'($urandom), 1'b0, 1'b1);
    strobes = 0;
    idle(10, 1'b1);
    check_val("flush_no_strobe", 32'(strobes), 32'd0);

    // free drops after the first strobe
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    strobes = 0;
    idle(5, 1'b0);
    idle(15, 1'b1);
    check_val("stall_rest", 32'(strobes), 32'd3);

    // reset during SEND with words queued
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    pulse_reset();
    cycle(1'b1, 24'h123456, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("post_rst_strobe", 32'(spi_wr_en), 32'd1);
    idle(4, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 2);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
